// File: rtl/mario_pkg.sv
// Shared types and constants for the sprite-list DMA engine and its helper blocks.
// The address helpers keep the wrap-around arithmetic in one place.
package mario_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ0  = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } dma_state_e;

    typedef logic [10:0] dma_cnt_t;

    localparam logic [10:0] DMA_SRC_BASE = 11'h100;
    localparam logic [9:0]  DMA_DST_BASE = 10'h000;
    localparam int          DMA_LEN      = 384;

    // RAM 7A is 2 KB, so source offsets wrap at 11 bits
    function automatic logic [10:0] src_addr(input logic [10:0] base, input dma_cnt_t cnt);
        return base + cnt;
    endfunction

    // Object RAM is 1 KB, so destination offsets wrap at 10 bits
    function automatic logic [9:0] dst_addr(input logic [9:0] base, input dma_cnt_t cnt);
        return 10'({1'b0, base} + cnt);
    endfunction

endpackage

// File: rtl/mario_sprite_xfer_if.sv
// Source-read / destination-write bus between the sprite DMA engine and the two RAMs.
// The engine is the master: it drives both address ports and receives RAM 7A read data.
interface mario_sprite_xfer_if;

    logic [10:0] dma_as;
    logic        dma_ces;
    logic [7:0]  dma_ds;
    logic [9:0]  dma_ad;
    logic [7:0]  dma_dd;
    logic        dma_ced;

    modport master (
        output dma_as,
        output dma_ces,
        input  dma_ds,
        output dma_ad,
        output dma_dd,
        output dma_ced
    );

    modport slave (
        input  dma_as,
        input  dma_ces,
        output dma_ds,
        input  dma_ad,
        input  dma_dd,
        input  dma_ced
    );

endinterface

// File: rtl/mario_edge_det.sv
// Enable-qualified rising-edge detector for latch-driven control bits.
// The pulse is only meaningful on a cycle where cen is high.
module mario_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic level,
    output logic rise
);

    logic level_d_r;

    // Level history, advanced once per enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d_r <= 1'b0;
        end else if (cen) begin
            level_d_r <= level;
        end
    end

    assign rise = cen & level & ~level_d_r;

endmodule

// File: rtl/mario_sprite_xfer.sv
// Sprite-list DMA: copies LEN bytes from RAM 7A to object RAM, one byte per 4 MHz enable,
// overlapping the next source read with the current destination write.
module mario_sprite_xfer
    import mario_pkg::*;
#(
    parameter logic [10:0] SRC_BASE = DMA_SRC_BASE,
    parameter logic [9:0]  DST_BASE = DMA_DST_BASE,
    parameter int          LEN      = DMA_LEN
) (
    input  logic                       I_CLK_48M,
    input  logic                       I_RESET,
    input  logic                       I_CEN_4M,
    input  logic                       I_DMA_TRIG,
    mario_sprite_xfer_if.master        dma,
    output logic                       O_BUSY,
    output logic                       O_DONE
);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_READ0  = 2'(READ0);
    localparam logic [1:0] S_STREAM = 2'(STREAM);
    localparam logic [1:0] S_FINISH = 2'(FINISH);

    localparam dma_cnt_t LEN_C  = 11'(LEN);
    localparam dma_cnt_t LAST_C = 11'(LEN - 1);

    logic        start_s;

    logic [1:0]  state_r,  state_s;
    dma_cnt_t    rd_cnt_r, rd_cnt_s;
    dma_cnt_t    wr_cnt_r, wr_cnt_s;
    logic [10:0] as_r,     as_s;
    logic        ces_r,    ces_s;
    logic [9:0]  ad_r,     ad_s;
    logic [7:0]  dd_r,     dd_s;
    logic        ced_r,    ced_s;
    logic        busy_r,   busy_s;
    logic        done_r,   done_s;

    mario_edge_det u_trig_edge (
        .clk   (I_CLK_48M),
        .rst   (I_RESET),
        .cen   (I_CEN_4M),
        .level (I_DMA_TRIG),
        .rise  (start_s)
    );

    // Next-state and next-output decode; strobes default low so they last one enable
    always_comb begin
        state_s  = state_r;
        rd_cnt_s = rd_cnt_r;
        wr_cnt_s = wr_cnt_r;
        as_s     = as_r;
        ces_s    = 1'b0;
        ad_s     = ad_r;
        dd_s     = dd_r;
        ced_s    = 1'b0;
        busy_s   = busy_r;
        done_s   = 1'b0;

        case (state_r)
            S_IDLE: begin
                // Edges seen in any other state are dropped, never queued
                if (start_s) begin
                    state_s  = S_READ0;
                    busy_s   = 1'b1;
                    rd_cnt_s = 11'd0;
                    wr_cnt_s = 11'd0;
                end else begin
                    state_s  = S_IDLE;
                end
            end

            S_READ0: begin
                ces_s    = 1'b1;
                as_s     = src_addr(SRC_BASE, rd_cnt_r);
                rd_cnt_s = rd_cnt_r + 11'd1;
                state_s  = S_STREAM;
            end

            S_STREAM: begin
                // Read data for the byte addressed last enable is on I_DMA_DS now
                ced_s    = 1'b1;
                ad_s     = dst_addr(DST_BASE, wr_cnt_r);
                dd_s     = dma.dma_ds;
                wr_cnt_s = wr_cnt_r + 11'd1;

                if (rd_cnt_r < LEN_C) begin
                    ces_s    = 1'b1;
                    as_s     = src_addr(SRC_BASE, rd_cnt_r);
                    rd_cnt_s = rd_cnt_r + 11'd1;
                end else begin
                    ces_s    = 1'b0;
                end

                // BUSY drops with the final write so it spans exactly LEN+1 enables
                if (wr_cnt_r == LAST_C) begin
                    state_s = S_FINISH;
                    busy_s  = 1'b0;
                end else begin
                    state_s = S_STREAM;
                end
            end

            S_FINISH: begin
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end

            default: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs, advanced only on the 4 MHz enable
    always_ff @(posedge I_CLK_48M or posedge I_RESET) begin
        if (I_RESET) begin
            state_r  <= S_IDLE;
            rd_cnt_r <= 11'd0;
            wr_cnt_r <= 11'd0;
            as_r     <= 11'd0;
            ces_r    <= 1'b0;
            ad_r     <= 10'd0;
            dd_r     <= 8'd0;
            ced_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (I_CEN_4M) begin
            state_r  <= state_s;
            rd_cnt_r <= rd_cnt_s;
            wr_cnt_r <= wr_cnt_s;
            as_r     <= as_s;
            ces_r    <= ces_s;
            ad_r     <= ad_s;
            dd_r     <= dd_s;
            ced_r    <= ced_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign dma.dma_as  = as_r;
    assign dma.dma_ces = ces_r;
    assign dma.dma_ad  = ad_r;
    assign dma.dma_dd  = dd_r;
    assign dma.dma_ced = ced_r;
    assign O_BUSY      = busy_r;
    assign O_DONE      = done_r;

endmodule

// File: tb/tb_mario_sprite_xfer.sv
// Scoreboard bench for mario_sprite_xfer: a default-parameter instance and a
// wrapping-source instance (SRC_BASE=0x7F0, LEN=32) share clock, enable and reset.
module tb_mario_sprite_xfer;

    localparam int LEN_A = 384;
    localparam int LEN_B = 32;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic cen    = 1'b0;
    logic stall  = 1'b0;
    logic trig_a = 1'b0;
    logic trig_b = 1'b0;
    logic busy_a, done_a, busy_b, done_b;

    int n_checks = 0;
    int n_pass   = 0;

    mario_sprite_xfer_if bus_a ();
    mario_sprite_xfer_if bus_b ();

    mario_sprite_xfer dut_a (
        .I_CLK_48M  (clk),
        .I_RESET    (rst),
        .I_CEN_4M   (cen),
        .I_DMA_TRIG (trig_a),
        .dma        (bus_a),
        .O_BUSY     (busy_a),
        .O_DONE     (done_a)
    );

    mario_sprite_xfer #(
        .SRC_BASE (11'h7F0),
        .DST_BASE (10'h000),
        .LEN      (LEN_B)
    ) dut_b (
        .I_CLK_48M  (clk),
        .I_RESET    (rst),
        .I_CEN_4M   (cen),
        .I_DMA_TRIG (trig_b),
        .dma        (bus_b),
        .O_BUSY     (busy_b),
        .O_DONE     (done_b)
    );

    // Expected traffic: {AD, DD} for writes, AS for reads
    logic [17:0] exp_wr_a [$];
    logic [17:0] exp_wr_b [$];
    logic [10:0] exp_rd_b [$];

    // Monitor-side model state for instance A
    int  en_idx      = 0;
    bit  a_on        = 1'b0;
    int  a_edge      = 0;
    int  a_wr        = 0;
    int  a_busy_cnt  = 0;
    int  a_done_cnt  = 0;
    bit  trig_a_prev = 1'b0;
    int  b_done_cnt  = 0;

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // 4 MHz enable: one clock in four, frozen while stall is set
    initial begin
        int div = 0;
        forever begin
            @(negedge clk);
            if (stall) begin
                cen = 1'b0;
            end else begin
                div = (div + 1) % 4;
                cen = (div == 0);
            end
        end
    end

    // RAM 7A models: data = low byte of the address, garbage when not enabled
    initial begin
        bus_a.dma_ds = 8'h00;
        bus_b.dma_ds = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus_a.dma_ds = bus_a.dma_ces ? bus_a.dma_as[7:0] : 8'hEE;
            bus_b.dma_ds = bus_b.dma_ces ? bus_b.dma_as[7:0] : 8'hEE;
        end
    end

    // Monitor: sample every enable at the following negedge
    initial begin
        logic [17:0] e_wr;
        logic [10:0] e_rd;
        bit exp_busy, exp_done;
        forever begin
            @(posedge clk);
            if (rst) begin
                a_on        = 1'b0;
                trig_a_prev = 1'b0;
            end else if (cen) begin
                en_idx++;
                if (a_on && en_idx > a_edge + LEN_A + 2) a_on = 1'b0;
                if (!a_on && trig_a && !trig_a_prev) begin
                    a_on       = 1'b1;
                    a_edge     = en_idx;
                    a_wr       = 0;
                    a_busy_cnt = 0;
                end
                trig_a_prev = trig_a;
                @(negedge clk);
                if (rst) begin
                    a_on = 1'b0;
                end else begin
                    exp_busy = a_on && (en_idx <= a_edge + LEN_A);
                    exp_done = a_on && (en_idx == a_edge + LEN_A + 2);
                    check(busy_a == exp_busy, "busy_a", busy_a, exp_busy);
                    check(done_a == exp_done, "done_a", done_a, exp_done);
                    if (busy_a) a_busy_cnt++;
                    if (done_a) a_done_cnt++;
                    if (a_on && en_idx == a_edge + 1)
                        check(bus_a.dma_ces && bus_a.dma_as == 11'h100, "first_read_a",
                              {bus_a.dma_ces, bus_a.dma_as}, {1'b1, 11'h100});
                    if (bus_a.dma_ced) begin
                        if (exp_wr_a.size() == 0) begin
                            check(1'b0, "unexpected_write_a", {bus_a.dma_ad, bus_a.dma_dd}, 64'd0);
                        end else begin
                            e_wr = exp_wr_a.pop_front();
                            check({bus_a.dma_ad, bus_a.dma_dd} == e_wr, "write_a",
                                  {bus_a.dma_ad, bus_a.dma_dd}, e_wr);
                            if (a_wr == 0)
                                check(en_idx - a_edge == 2, "first_write_latency_a", en_idx - a_edge, 2);
                            a_wr++;
                        end
                    end
                    if (exp_done) begin
                        check(a_busy_cnt == LEN_A + 1, "busy_enables_a", a_busy_cnt, LEN_A + 1);
                        check(exp_wr_a.size() == 0, "writes_left_a", exp_wr_a.size(), 0);
                    end
                    if (bus_b.dma_ces) begin
                        if (exp_rd_b.size() == 0) begin
                            check(1'b0, "unexpected_read_b", bus_b.dma_as, 64'd0);
                        end else begin
                            e_rd = exp_rd_b.pop_front();
                            check(bus_b.dma_as == e_rd, "read_addr_b", bus_b.dma_as, e_rd);
                        end
                    end
                    if (bus_b.dma_ced) begin
                        if (exp_wr_b.size() == 0) begin
                            check(1'b0, "unexpected_write_b", {bus_b.dma_ad, bus_b.dma_dd}, 64'd0);
                        end else begin
                            e_wr = exp_wr_b.pop_front();
                            check({bus_b.dma_ad, bus_b.dma_dd} == e_wr, "write_b",
                                  {bus_b.dma_ad, bus_b.dma_dd}, e_wr);
                        end
                    end
                    if (done_b) b_done_cnt++;
                end
            end
        end
    end

    task automatic step_en(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!cen) @(posedge clk);
        end
        #1;
    endtask

    // Write n lands at AD=n with DD = (0x100+n) & 0xFF
    task automatic start_a();
        for (int n = 0; n < LEN_A; n++)
            exp_wr_a.push_back({10'(n), 8'((32'h100 + n) & 32'hFF)});
        trig_a = 1'b1;
        step_en(1);
    endtask

    // Source 0x7F0..0x7FF then wraps to 0x000..0x00F
    task automatic push_b();
        logic [10:0] a;
        for (int i = 0; i < LEN_B; i++) begin
            a = (i < 16) ? 11'(32'h7F0 + i) : 11'(i - 16);
            exp_rd_b.push_back(a);
            exp_wr_b.push_back({10'(i), a[7:0]});
        end
    endtask

    task automatic wait_wr_a(input int n);
        int t = 0;
        while (a_wr < n && t < 3000) begin
            step_en(1);
            t++;
        end
        check(a_wr >= n, "wait_write_a", a_wr, n);
    endtask

    task automatic check_outputs_zero(input string name);
        check({busy_a, done_a, bus_a.dma_ces, bus_a.dma_ced, bus_a.dma_as, bus_a.dma_ad, bus_a.dma_dd} == 0,
              name, {busy_a, done_a, bus_a.dma_ces, bus_a.dma_ced, bus_a.dma_as, bus_a.dma_ad, bus_a.dma_dd}, 64'd0);
        check({busy_b, done_b, bus_b.dma_ces, bus_b.dma_ced, bus_b.dma_as, bus_b.dma_ad, bus_b.dma_dd} == 0,
              name, {busy_b, done_b, bus_b.dma_ces, bus_b.dma_ced, bus_b.dma_as, bus_b.dma_ad, bus_b.dma_dd}, 64'd0);
    endtask

    initial begin
        int          k;
        logic [63:0] hold_exp;
        logic [63:0] hold_act;

        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        rst = 1'b0;
        step_en(3);

        // Transfer 1, then trigger held high for 2000 enables
        start_a();
        step_en(2000);
        check(a_wr == LEN_A, "t1_write_count", a_wr, LEN_A);
        check(a_done_cnt == 1, "t1_done_count", a_done_cnt, 1);

        // Transfer 2 with a second edge at write #100 that must be ignored
        trig_a = 1'b0;
        step_en(2);
        start_a();
        wait_wr_a(100);
        trig_a = 1'b0;
        step_en(1);
        trig_a = 1'b1;
        step_en(400);
        check(a_wr == LEN_A, "t2_write_count", a_wr, LEN_A);
        check(a_done_cnt == 2, "t2_done_count", a_done_cnt, 2);

        // Transfer 3 with the enable frozen for 50 clocks mid-stream
        trig_a = 1'b0;
        step_en(2);
        start_a();
        wait_wr_a(50);
        k = a_wr;
        stall = 1'b1;
        hold_exp = {1'b1, 1'b1, 1'b1, 11'(32'h100 + k + 1), 10'(k), 8'(k & 255)};
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            hold_act = {busy_a, bus_a.dma_ces, bus_a.dma_ced, bus_a.dma_as, bus_a.dma_ad, bus_a.dma_dd};
            check(hold_act == hold_exp, "stall_hold", hold_act, hold_exp);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        step_en(400);
        check(a_wr == LEN_A, "t3_write_count", a_wr, LEN_A);
        check(a_done_cnt == 3, "t3_done_count", a_done_cnt, 3);

        // Transfer 4 aborted by reset at write #200
        trig_a = 1'b0;
        step_en(2);
        start_a();
        wait_wr_a(200);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_reset_outputs");
        exp_wr_a.delete();
        trig_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        step_en(5);
        check(a_done_cnt == 3, "abort_no_done", a_done_cnt, 3);

        // Transfer 5 restarts from AD=0
        start_a();
        step_en(400);
        check(a_wr == LEN_A, "t5_write_count", a_wr, LEN_A);
        check(a_done_cnt == 4, "t5_done_count", a_done_cnt, 4);

        // Wrapping source; an edge on the FINISH enable (edge+34) is dropped
        push_b();
        trig_b = 1'b1;
        step_en(1);
        step_en(32);
        trig_b = 1'b0;
        step_en(1);
        trig_b = 1'b1;
        step_en(6);
        check(b_done_cnt == 1, "b1_done_count", b_done_cnt, 1);
        check(exp_wr_b.size() == 0 && exp_rd_b.size() == 0, "b1_traffic_left",
              exp_wr_b.size() + exp_rd_b.size(), 0);

        // A fresh edge after FINISH is accepted
        trig_b = 1'b0;
        step_en(2);
        push_b();
        trig_b = 1'b1;
        step_en(40);
        check(b_done_cnt == 2, "b2_done_count", b_done_cnt, 2);
        check(exp_wr_b.size() == 0 && exp_rd_b.size() == 0, "b2_traffic_left",
              exp_wr_b.size() + exp_rd_b.size(), 0);
        check(busy_b == 1'b0, "b2_idle", busy_b, 0);
        check(exp_wr_a.size() == 0, "a_traffic_left", exp_wr_a.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
